// File: rtl/core_wb_dbridge_if.sv
// Signal bundle for the core data port and the Wishbone B4 pipelined data-side bus.
// The bridge uses the master modport; the surrounding core/interconnect model uses slave.
interface core_wb_dbridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          core_req_i;
  logic          core_we_i;
  logic [AW-1:0] core_adr_i;
  logic [DW-1:0] core_wdat_i;
  logic [SW-1:0] core_sel_i;
  logic          core_rdy_o;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          core_err_o;

  logic          data_wb_cyc_o;
  logic          data_wb_stb_o;
  logic          data_wb_we_o;
  logic [AW-1:0] data_wb_adr_o;
  logic [DW-1:0] data_wb_dat_o;
  logic [SW-1:0] data_wb_sel_o;
  logic          data_wb_stall_i;
  logic          data_wb_ack_i;
  logic          data_wb_err_i;
  logic [DW-1:0] data_wb_dat_i;

  modport master (
    input  core_req_i, core_we_i, core_adr_i, core_wdat_i, core_sel_i,
    output core_rdy_o, core_rvalid_o, core_rdata_o, core_err_o,
    output data_wb_cyc_o, data_wb_stb_o, data_wb_we_o, data_wb_adr_o, data_wb_dat_o, data_wb_sel_o,
    input  data_wb_stall_i, data_wb_ack_i, data_wb_err_i, data_wb_dat_i
  );

  modport slave (
    output core_req_i, core_we_i, core_adr_i, core_wdat_i, core_sel_i,
    input  core_rdy_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  data_wb_cyc_o, data_wb_stb_o, data_wb_we_o, data_wb_adr_o, data_wb_dat_o, data_wb_sel_o,
    output data_wb_stall_i, data_wb_ack_i, data_wb_err_i, data_wb_dat_i
  );
endinterface

// File: rtl/core_wb_dbridge.sv
// Core-to-Wishbone B4 pipelined data bridge: request FIFO, outstanding-transfer tracking,
// in-order responses and a bus-hang timeout that flushes outstanding transfers as errors.
module core_wb_dbridge #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int REQ_DEPTH = 2,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              data_wb_clk_i,
  input  logic              data_wb_rst_i,
  core_wb_dbridge_if.master bus
);
  localparam int SW = DW / 8;
  localparam int PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CW = $clog2(REQ_DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 1 + AW + DW + SW;

  // state | meaning
  // IDLE  | nothing queued, nothing outstanding
  // BUSY  | requests queued and/or transfers outstanding
  // ABORT | bus hung: bus released, one error response per outstanding transfer
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        r_state, w_state_nxt;
  logic [EW-1:0] r_mem [REQ_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_outst;
  logic [TW-1:0] r_timer;
  logic          r_rvalid, r_err;
  logic [DW-1:0] r_rdata;

  logic          w_full, w_empty, w_push, w_pop, w_stb, w_cyc;
  logic          w_any_resp, w_bus_resp, w_abort_emit, w_dec, w_timeout;
  logic [EW-1:0] w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(REQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full       = (r_count == CW'(REQ_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = bus.core_req_i & ~w_full;
  assign w_pop        = w_stb & ~bus.data_wb_stall_i;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_any_resp   = bus.data_wb_ack_i | bus.data_wb_err_i;
  assign w_bus_resp   = w_any_resp && (r_outst != '0) && (r_state != ABORT);
  assign w_abort_emit = (r_state == ABORT) && (r_outst != '0);
  assign w_dec        = w_bus_resp | w_abort_emit;
  assign w_timeout    = (TIMEOUT != 0) && (r_state != ABORT) && (r_outst != '0) &&
                        (r_timer == TW'(TIMEOUT - 1)) && !w_any_resp;

  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb       = 1'b0;
    w_cyc       = 1'b0;
    if (r_state != ABORT) begin
      w_stb = !w_empty && (r_outst < 4'(MAX_OUTST));
      w_cyc = w_stb || (r_outst != '0);
    end
    unique case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = BUSY;
      BUSY: begin
        if (w_timeout)                         w_state_nxt = ABORT;
        else if (w_empty && (r_outst == '0))   w_state_nxt = IDLE;
      end
      // leave on the cycle that emits the last flushed response
      ABORT: if (r_outst <= 4'd1) w_state_nxt = w_empty ? IDLE : BUSY;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge data_wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.core_we_i, bus.core_adr_i, bus.core_wdat_i, bus.core_sel_i};
  end

  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
      r_timer  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      case ({w_pop, w_dec})
        2'b10:   r_outst <= r_outst + 4'd1;
        2'b01:   r_outst <= r_outst - 4'd1;
        default: ;
      endcase
      if (w_any_resp || (r_outst == '0) || (r_state == ABORT) || w_timeout) r_timer <= '0;
      else                                                                  r_timer <= r_timer + TW'(1);
      r_rvalid <= w_dec;
      r_rdata  <= w_bus_resp ? bus.data_wb_dat_i : '0;
      r_err    <= w_bus_resp ? bus.data_wb_err_i : w_abort_emit;
    end
  end

  assign bus.core_rdy_o    = ~w_full;
  assign bus.core_rvalid_o = r_rvalid;
  assign bus.core_rdata_o  = r_rdata;
  assign bus.core_err_o    = r_err;
  assign bus.data_wb_cyc_o = w_cyc;
  assign bus.data_wb_stb_o = w_stb;
  assign bus.data_wb_we_o  = w_stb & w_head[EW-1];
  assign bus.data_wb_adr_o = w_stb ? w_head[EW-2 -: AW] : '0;
  assign bus.data_wb_dat_o = w_stb ? w_head[DW+SW-1 -: DW] : '0;
  assign bus.data_wb_sel_o = w_stb ? w_head[SW-1:0] : '0;
endmodule

// File: tb/tb_core_wb_dbridge.sv
// Directed bench for core_wb_dbridge: a per-cycle vector table plus hand-written sequences for
// back-pressure, outstanding limit, timeout abort and mid-transfer reset.
module tb_core_wb_dbridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n_rv = 0;

  always #5 clk = ~clk;

  core_wb_dbridge_if #(.AW(32), .DW(32)) bus ();

  core_wb_dbridge #(.AW(32), .DW(32), .REQ_DEPTH(2), .MAX_OUTST(4), .TIMEOUT(8)) dut (
    .data_wb_clk_i(clk),
    .data_wb_rst_i(rst),
    .bus          (bus)
  );

  typedef struct packed {
    logic req; logic we; logic [31:0] adr; logic [31:0] wdat; logic [3:0] sel;
    logic stall; logic ack; logic err; logic [31:0] dat;
    logic e_rdy; logic e_stb; logic e_cyc; logic e_we; logic [31:0] e_adr; logic [31:0] e_wdat;
    logic [3:0] e_sel; logic e_rv; logic [31:0] e_rdata; logic e_err;
  } vec_t;

  typedef struct packed {logic [31:0] rdata; logic err;} resp_t;

  vec_t  vt[$];
  resp_t exp_q[$];

  function automatic vec_t vec(
    input logic req, we, input logic [31:0] adr, wdat, input logic [3:0] sel,
    input logic stall, ack, err, input logic [31:0] dat,
    input logic e_rdy, e_stb, e_cyc, e_we, input logic [31:0] e_adr, e_wdat, input logic [3:0] e_sel,
    input logic e_rv, input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v = '{req, we, adr, wdat, sel, stall, ack, err, dat,
          e_rdy, e_stb, e_cyc, e_we, e_adr, e_wdat, e_sel, e_rv, e_rdata, e_err};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, we, input logic [31:0] adr, wdat, input logic [3:0] sel,
                       input logic stall, ack, err, input logic [31:0] dat);
    bus.core_req_i      = req;
    bus.core_we_i       = we;
    bus.core_adr_i      = adr;
    bus.core_wdat_i     = wdat;
    bus.core_sel_i      = sel;
    bus.data_wb_stall_i = stall;
    bus.data_wb_ack_i   = ack;
    bus.data_wb_err_i   = err;
    bus.data_wb_dat_i   = dat;
  endtask

  task automatic idle(input logic stall);
    drive(0, 0, 0, 0, 0, stall, 0, 0, 0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic stall);
    drive(1, 0, adr, 0, 4'hF, stall, 0, 0, 0);
  endtask

  task automatic ack_with(input logic [31:0] dat, input logic err);
    resp_t e;
    drive(0, 0, 0, 0, 0, 0, ~err, err, dat);
    e.rdata = dat;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard for responses in the hand-written sequences.
  task automatic sample_resp();
    resp_t e;
    if (bus.core_rvalid_o) begin
      n_rv++;
      if (exp_q.size() == 0) chk("resp_unexpected", bus.core_rvalid_o, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("resp_rdata", bus.core_rdata_o, e.rdata);
        chk("resp_err", bus.core_err_o, e.err);
      end
    end
  endtask

  initial begin
    int pushed, accepted, base;

    idle(0);
    #1;
    chk("rst_rdy", bus.core_rdy_o, 1);
    chk("rst_stb", bus.data_wb_stb_o, 0);
    chk("rst_cyc", bus.data_wb_cyc_o, 0);
    chk("rst_rvalid", bus.core_rvalid_o, 0);
    chk("rst_err", bus.core_err_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single read, spurious ack, three reads with middle error, stalled write
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(1,0,32'h100,0,4'hF, 0,0,0,0,     1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,1,1,0,32'h100,0,4'hF, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,1,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,1,0,32'hDEADBEEF,   1,0,1,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 1,32'hDEADBEEF,0));
    vt.push_back(vec(0,0,0,0,0, 0,1,0,32'h12345678,   1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(1,0,32'h200,0,4'hF, 0,0,0,0,     1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(1,0,32'h204,0,4'hF, 0,0,0,0,     1,1,1,0,32'h200,0,4'hF, 0,0,0));
    vt.push_back(vec(1,0,32'h208,0,4'hF, 0,1,0,32'h11111111, 1,1,1,0,32'h204,0,4'hF, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,1,32'h22222222,   1,1,1,0,32'h208,0,4'hF, 1,32'h11111111,0));
    vt.push_back(vec(0,0,0,0,0, 0,1,0,32'h33333333,   1,0,1,0,0,0,0, 1,32'h22222222,1));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 1,32'h33333333,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(1,1,32'h300,32'hA5A5A5A5,4'h3, 0,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 1,0,0,0,              1,1,1,1,32'h300,32'hA5A5A5A5,4'h3, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 1,0,0,0,              1,1,1,1,32'h300,32'hA5A5A5A5,4'h3, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,1,1,1,32'h300,32'hA5A5A5A5,4'h3, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,1,0,32'h0BADF00D,   1,0,1,0,0,0,0, 0,0,0));
    vt.push_back(vec(0,0,0,0,0, 0,0,0,0,              1,0,0,0,0,0,0, 1,32'h0BADF00D,0));

    foreach (vt[k]) begin
      drive(vt[k].req, vt[k].we, vt[k].adr, vt[k].wdat, vt[k].sel,
            vt[k].stall, vt[k].ack, vt[k].err, vt[k].dat);
      #1;
      chk($sformatf("v%0d_rdy", k), bus.core_rdy_o, vt[k].e_rdy);
      chk($sformatf("v%0d_stb", k), bus.data_wb_stb_o, vt[k].e_stb);
      chk($sformatf("v%0d_cyc", k), bus.data_wb_cyc_o, vt[k].e_cyc);
      chk($sformatf("v%0d_rvalid", k), bus.core_rvalid_o, vt[k].e_rv);
      if (vt[k].e_stb) begin
        chk($sformatf("v%0d_we", k), bus.data_wb_we_o, vt[k].e_we);
        chk($sformatf("v%0d_adr", k), bus.data_wb_adr_o, vt[k].e_adr);
        chk($sformatf("v%0d_dat", k), bus.data_wb_dat_o, vt[k].e_wdat);
        chk($sformatf("v%0d_sel", k), bus.data_wb_sel_o, vt[k].e_sel);
      end
      if (vt[k].e_rv) begin
        chk($sformatf("v%0d_rdata", k), bus.core_rdata_o, vt[k].e_rdata);
        chk($sformatf("v%0d_rerr", k), bus.core_err_o, vt[k].e_err);
      end
      @(negedge clk);
    end

    // four writes under a 3-cycle stall, then four in-order acks
    base = n_rv;
    for (int c = 0; c < 7; c++) begin
      int w;
      w = (c < 2) ? c : (c < 5) ? 2 : (c == 5) ? 3 : -1;
      if (w >= 0) drive(1, 1, 32'h400 + 4 * w, 32'hC0DE0000 + w, 4'hF, (c < 3), 0, 0, 0);
      else        idle(0);
      #1;
      sample_resp();
      chk($sformatf("wr%0d_rdy", c), bus.core_rdy_o, (c == 2 || c == 3) ? 0 : 1);
      if (c > 0) begin
        chk($sformatf("wr%0d_stb", c), bus.data_wb_stb_o, 1);
        chk($sformatf("wr%0d_we", c), bus.data_wb_we_o, 1);
        chk($sformatf("wr%0d_adr", c), bus.data_wb_adr_o, 32'h400 + 4 * ((c < 4) ? 0 : c - 3));
        chk($sformatf("wr%0d_dat", c), bus.data_wb_dat_o, 32'hC0DE0000 + ((c < 4) ? 0 : c - 3));
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      ack_with(32'hA0 + k, 0);
      #1;
      sample_resp();
      chk("wr_ack_stb", bus.data_wb_stb_o, 0);
      chk("wr_ack_cyc", bus.data_wb_cyc_o, 1);
      @(negedge clk);
    end
    idle(0);
    #1;
    sample_resp();
    chk("wr_drain_cyc", bus.data_wb_cyc_o, 0);
    @(negedge clk);
    chk("wr_resp_count", n_rv - base, 4);
    chk("wr_queue_empty", exp_q.size(), 0);

    // six reads against MAX_OUTST=4 with acks withheld
    base = n_rv;
    pushed = 0;
    accepted = 0;
    for (int c = 0; c < 7; c++) begin
      if (pushed < 6) rd(32'h500 + 4 * pushed, 0);
      else            idle(0);
      #1;
      sample_resp();
      if (bus.core_req_i && bus.core_rdy_o) pushed++;
      if (bus.data_wb_stb_o && !bus.data_wb_stall_i) accepted++;
      @(negedge clk);
    end
    ack_with(32'hB0, 0);
    #1;
    sample_resp();
    chk("mo_accepted", accepted, 4);
    chk("mo_pushed", pushed, 6);
    chk("mo_full_stb", bus.data_wb_stb_o, 0);
    chk("mo_full_cyc", bus.data_wb_cyc_o, 1);
    chk("mo_full_rdy", bus.core_rdy_o, 0);
    @(negedge clk);
    idle(0);
    #1;
    sample_resp();
    chk("mo_rel1_stb", bus.data_wb_stb_o, 1);
    chk("mo_rel1_adr", bus.data_wb_adr_o, 32'h510);
    @(negedge clk);
    ack_with(32'hB1, 0);
    #1;
    sample_resp();
    chk("mo_hold_stb", bus.data_wb_stb_o, 0);
    @(negedge clk);
    idle(0);
    #1;
    sample_resp();
    chk("mo_rel2_stb", bus.data_wb_stb_o, 1);
    chk("mo_rel2_adr", bus.data_wb_adr_o, 32'h514);
    @(negedge clk);
    for (int k = 2; k < 6; k++) begin
      ack_with(32'hB0 + k, 0);
      #1;
      sample_resp();
      chk("mo_drain_stb", bus.data_wb_stb_o, 0);
      @(negedge clk);
    end
    idle(0);
    #1;
    sample_resp();
    chk("mo_end_cyc", bus.data_wb_cyc_o, 0);
    @(negedge clk);
    chk("mo_resp_count", n_rv - base, 6);

    // timeout: two reads issued, no ack, abort flushes two error responses
    base = n_rv;
    rd(32'h600, 0);
    #1; sample_resp();
    @(negedge clk);
    rd(32'h604, 0);
    #1; sample_resp();
    chk("to_issue0_adr", bus.data_wb_adr_o, 32'h600);
    @(negedge clk);
    idle(0);
    #1; sample_resp();
    chk("to_issue1_adr", bus.data_wb_adr_o, 32'h604);
    chk("to_issue1_stb", bus.data_wb_stb_o, 1);
    @(negedge clk);
    for (int n = 3; n < 10; n++) begin
      idle(0);
      #1; sample_resp();
      chk($sformatf("to_wait%0d_cyc", n), bus.data_wb_cyc_o, 1);
      @(negedge clk);
    end
    begin
      resp_t e;
      e.rdata = 0;
      e.err   = 1;
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A5A5A);
    #1; sample_resp();
    chk("to_abort_cyc", bus.data_wb_cyc_o, 0);
    chk("to_abort_stb", bus.data_wb_stb_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A);
    #1; sample_resp();
    chk("to_abort1_cyc", bus.data_wb_cyc_o, 0);
    @(negedge clk);
    idle(0);
    #1; sample_resp();
    chk("to_flush_count", n_rv - base, 2);
    @(negedge clk);
    idle(0);
    #1; sample_resp();
    chk("to_after_rvalid", bus.core_rvalid_o, 0);
    chk("to_after_cyc", bus.data_wb_cyc_o, 0);
    chk("to_after_rdy", bus.core_rdy_o, 1);
    @(negedge clk);
    rd(32'h700, 0);
    #1; sample_resp();
    @(negedge clk);
    idle(0);
    #1; sample_resp();
    chk("to_resume_stb", bus.data_wb_stb_o, 1);
    chk("to_resume_adr", bus.data_wb_adr_o, 32'h700);
    @(negedge clk);
    ack_with(32'h77, 0);
    #1; sample_resp();
    @(negedge clk);
    idle(0);
    #1; sample_resp();
    chk("to_resume_cyc", bus.data_wb_cyc_o, 0);
    @(negedge clk);
    chk("to_resp_count", n_rv - base, 3);
    chk("to_queue_empty", exp_q.size(), 0);

    // reset with three outstanding and the FIFO full
    base = n_rv;
    for (int c = 0; c < 5; c++) begin
      rd(32'h800 + 4 * c, (c == 4));
      #1; sample_resp();
      @(negedge clk);
    end
    idle(1);
    #1;
    sample_resp();
    chk("rs_pre_rdy", bus.core_rdy_o, 0);
    chk("rs_pre_cyc", bus.data_wb_cyc_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_rdy", bus.core_rdy_o, 1);
    chk("rs_stb", bus.data_wb_stb_o, 0);
    chk("rs_cyc", bus.data_wb_cyc_o, 0);
    chk("rs_adr", bus.data_wb_adr_o, 0);
    chk("rs_rvalid", bus.core_rvalid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 0, 1, (c == 1), 32'hFFFF0000 + c);
      #1;
      sample_resp();
      chk("rs_late_cyc", bus.data_wb_cyc_o, 0);
      chk("rs_late_rdy", bus.core_rdy_o, 1);
      @(negedge clk);
    end
    idle(0);
    #1;
    sample_resp();
    @(negedge clk);
    chk("rs_resp_count", n_rv - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
